dec_dispatch_ctrl: RTL and testbench

//  In-order dispatch controller between the 4-wide decode ways and the two reservation stations and the ROB.

---
 rtl/ace_pkg.sv | 7 +
 rtl/disp_credit_ctr.sv | 30 +++
 rtl/dec_dispatch_ctrl.sv | 74 +++++++
 tb/tb_dec_dispatch_ctrl.sv | 88 ++++++++
 4 files changed

// File: rtl/ace_pkg.sv
// ace_pkg: shared dispatch widths and FSM state encoding.
package ace_pkg;
  localparam int DISP_W = 4;
  localparam int RS_NUM = 2;
  localparam int CNT_W  = $clog2(DISP_W + 1);
  typedef enum logic [1:0] {RUN, EXC, DRAIN} disp_state_e;
endpackage

// File: rtl/disp_credit_ctr.sv
// disp_credit_ctr: free-entry credit counter with alloc/release and refill to ceiling.
module disp_credit_ctr
  import ace_pkg::*;
#(
  parameter int CEIL = 8,
  parameter int CW   = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             full_i,
  input  logic [CNT_W-1:0] alloc_i,
  input  logic [CNT_W-1:0] rel_i,
  output logic [CW-1:0]    credit_o
);
  logic [CW:0]   sum;
  logic [CW-1:0] credit_d, credit_q;
  always_comb begin
    sum      = {1'b0, credit_q} - (CW+1)'(alloc_i) + (CW+1)'(rel_i);
    credit_d = full_i ? CW'(CEIL) : (sum > (CW+1)'(CEIL) ? CW'(CEIL) : sum[CW-1:0]);
  end
  always_ff @(posedge clock) begin
    if (!reset_n) credit_q <= CW'(CEIL);
    else credit_q <= credit_d;
  end
  // releasing more entries than were ever allocated is an upstream protocol bug
  always_ff @(posedge clock) begin
    if (reset_n && !full_i) assert (sum <= (CW+1)'(CEIL));
  end
  assign credit_o = credit_q;
endmodule

// File: rtl/dec_dispatch_ctrl.sv
// dec_dispatch_ctrl: in-order 4-wide dispatch prefix select with RS/ROB credits and illegal-op parking.
module dec_dispatch_ctrl
  import ace_pkg::*;
#(
  parameter int RS_DEPTH  = 8,
  parameter int ROB_DEPTH = 32,
  parameter int CW        = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              retire_flush_i,
  input  logic [DISP_W-1:0] dec_vld_i,
  input  logic [DISP_W-1:0] dec_rs_id_i,
  input  logic [DISP_W-1:0] dec_illegal_i,
  input  logic [CNT_W-1:0]  rs0_release_i,
  input  logic [CNT_W-1:0]  rs1_release_i,
  input  logic [CNT_W-1:0]  rob_release_i,
  output logic [DISP_W-1:0] disp_vld_o,
  output logic [CNT_W-1:0]  deq_cnt_o,
  output logic              exc_vld_o,
  output logic              stall_o,
  output logic [CW-1:0]     rs0_credit_o,
  output logic [CW-1:0]     rs1_credit_o,
  output logic [CW-1:0]     rob_credit_o
);
  disp_state_e      state_d, state_q;
  logic             exc_q, ok, run, full;
  logic [CNT_W-1:0] n0, n1;
  assign run  = state_q == RUN;
  assign full = retire_flush_i | (state_q == DRAIN);
  // slot k needs ROB > k and its RS above the count already taken by earlier slots
  always_comb begin
    disp_vld_o = '0;
    n0 = '0;
    n1 = '0;
    ok = reset_n & run & ~retire_flush_i;
    for (int k = 0; k < DISP_W; k++) begin
      ok = ok & dec_vld_i[k] & ~dec_illegal_i[k] & (rob_credit_o > CW'(k)) &
           (dec_rs_id_i[k] ? rs1_credit_o > CW'(n1) : rs0_credit_o > CW'(n0));
      disp_vld_o[k] = ok;
      n0 = n0 + CNT_W'(ok & ~dec_rs_id_i[k]);
      n1 = n1 + CNT_W'(ok & dec_rs_id_i[k]);
    end
  end
  assign deq_cnt_o = n0 + n1;
  assign exc_vld_o = exc_q;
  assign stall_o   = dec_vld_i[0] & ~disp_vld_o[0] & run & ~retire_flush_i;
  always_comb begin
    state_d = retire_flush_i ? (state_q == EXC ? DRAIN : RUN) :
              state_q == DRAIN ? RUN :
              (run && dec_vld_i[0] && dec_illegal_i[0]) ? EXC : state_q;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= RUN;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exc_q   <= state_d == EXC;
    end
  end
  disp_credit_ctr #(.CEIL(RS_DEPTH), .CW(CW)) u_rs0 (
    .clock(clock), .reset_n(reset_n), .full_i(full),
    .alloc_i(n0), .rel_i(rs0_release_i), .credit_o(rs0_credit_o)
  );
  disp_credit_ctr #(.CEIL(RS_DEPTH), .CW(CW)) u_rs1 (
    .clock(clock), .reset_n(reset_n), .full_i(full),
    .alloc_i(n1), .rel_i(rs1_release_i), .credit_o(rs1_credit_o)
  );
  disp_credit_ctr #(.CEIL(ROB_DEPTH), .CW(CW)) u_rob (
    .clock(clock), .reset_n(reset_n), .full_i(full),
    .alloc_i(deq_cnt_o), .rel_i(rob_release_i), .credit_o(rob_credit_o)
  );
endmodule

// File: tb/tb_dec_dispatch_ctrl.sv
// tb_dec_dispatch_ctrl: directed scoreboard bench for the dispatch controller.
module tb_dec_dispatch_ctrl;
  logic       clock = 1'b0;
  logic       reset_n, retire_flush_i;
  logic [3:0] dec_vld_i, dec_rs_id_i, dec_illegal_i;
  logic [2:0] rs0_release_i, rs1_release_i, rob_release_i;
  logic [3:0] disp_vld_o;
  logic [2:0] deq_cnt_o;
  logic       exc_vld_o, stall_o;
  logic [5:0] rs0_credit_o, rs1_credit_o, rob_credit_o;
  int         errors = 0;
  int         checks = 0;
  typedef struct packed {
    logic [3:0] disp;
    logic [2:0] deq;
    logic       stall;
    logic       exc;
    logic [5:0] rs0, rs1, rob;
  } exp_t;
  exp_t sb[$];
  always #5 clock = ~clock;
  dec_dispatch_ctrl dut (
    .clock(clock), .reset_n(reset_n), .retire_flush_i(retire_flush_i),
    .dec_vld_i(dec_vld_i), .dec_rs_id_i(dec_rs_id_i), .dec_illegal_i(dec_illegal_i),
    .rs0_release_i(rs0_release_i), .rs1_release_i(rs1_release_i), .rob_release_i(rob_release_i),
    .disp_vld_o(disp_vld_o), .deq_cnt_o(deq_cnt_o), .exc_vld_o(exc_vld_o), .stall_o(stall_o),
    .rs0_credit_o(rs0_credit_o), .rs1_credit_o(rs1_credit_o), .rob_credit_o(rob_credit_o)
  );
  task automatic chk(input string tag, input int step, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, exp);
    end
  endtask
  task automatic step(input int id, input logic rn, input logic fl, input logic [3:0] vld,
                      input logic [3:0] rs, input logic [3:0] ill, input logic [2:0] r0,
                      input logic [2:0] r1, input logic [2:0] rb, input exp_t e);
    exp_t got;
    @(posedge clock);
    #1;
    reset_n = rn; retire_flush_i = fl; dec_vld_i = vld; dec_rs_id_i = rs; dec_illegal_i = ill;
    rs0_release_i = r0; rs1_release_i = r1; rob_release_i = rb;
    sb.push_back(e);
    @(negedge clock);
    got = sb.pop_front();
    chk("disp_vld", id, {4'h0, disp_vld_o}, {4'h0, got.disp});
    chk("deq_cnt", id, {5'h0, deq_cnt_o}, {5'h0, got.deq});
    chk("stall", id, {7'h0, stall_o}, {7'h0, got.stall});
    chk("exc_vld", id, {7'h0, exc_vld_o}, {7'h0, got.exc});
    chk("rs0_credit", id, {2'h0, rs0_credit_o}, {2'h0, got.rs0});
    chk("rs1_credit", id, {2'h0, rs1_credit_o}, {2'h0, got.rs1});
    chk("rob_credit", id, {2'h0, rob_credit_o}, {2'h0, got.rob});
  endtask
  initial begin
    reset_n = 1'b0; retire_flush_i = 1'b0; dec_vld_i = '0; dec_rs_id_i = '0; dec_illegal_i = '0;
    rs0_release_i = '0; rs1_release_i = '0; rob_release_i = '0;
    repeat (2) @(posedge clock);
    step(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, '{4'b0000, 0, 0, 0, 8, 8, 32});
    step(1, 1, 0, 4'b1111, 4'b0101, 4'b0000, 0, 0, 0, '{4'b1111, 4, 0, 0, 8, 8, 32});
    step(2, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, '{4'b0000, 0, 0, 0, 6, 6, 28});
    step(3, 1, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, '{4'b1111, 4, 0, 0, 6, 6, 28});
    step(4, 1, 0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0, '{4'b0001, 1, 0, 0, 2, 6, 24});
    step(5, 1, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, '{4'b0001, 1, 0, 0, 1, 6, 23});
    step(6, 1, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, '{4'b0000, 0, 1, 0, 0, 6, 22});
    step(7, 1, 0, 4'b1111, 4'b1110, 4'b0000, 4, 0, 0, '{4'b0000, 0, 1, 0, 0, 6, 22});
    step(8, 1, 0, 4'b1111, 4'b0000, 4'b0100, 0, 0, 0, '{4'b0011, 2, 0, 0, 4, 6, 22});
    step(9, 1, 0, 4'b1111, 4'b0000, 4'b0001, 0, 0, 0, '{4'b0000, 0, 1, 0, 2, 6, 20});
    step(10, 1, 0, 4'b1111, 4'b0000, 4'b0001, 0, 0, 0, '{4'b0000, 0, 0, 1, 2, 6, 20});
    step(11, 1, 1, 4'b1111, 4'b0000, 4'b0001, 0, 0, 0, '{4'b0000, 0, 0, 1, 2, 6, 20});
    step(12, 1, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, '{4'b0000, 0, 0, 0, 8, 8, 32});
    step(13, 1, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, '{4'b1111, 4, 0, 0, 8, 8, 32});
    for (int i = 0; i < 6; i++)
      step(14 + i, 1, 0, 4'b1111, 4'b0101, 4'b0000, 2, 2, 0,
           '{4'b1111, 4, 0, 0, 4, 8, 6'(28 - 4 * i)});
    step(20, 1, 0, 4'b0011, 4'b0101, 4'b0000, 0, 0, 0, '{4'b0011, 2, 0, 0, 4, 8, 4});
    step(21, 1, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 3, '{4'b0011, 2, 0, 0, 3, 7, 2});
    step(22, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, '{4'b0000, 0, 0, 0, 1, 7, 3});
    step(23, 1, 0, 4'b0001, 4'b0000, 4'b0001, 0, 0, 0, '{4'b0000, 0, 1, 0, 1, 7, 3});
    step(24, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, '{4'b0000, 0, 0, 1, 1, 7, 3});
    step(25, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, '{4'b0000, 0, 0, 1, 1, 7, 3});
    step(26, 1, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, '{4'b1111, 4, 0, 0, 8, 8, 32});
    step(27, 1, 1, 4'b1111, 4'b0000, 4'b0000, 0, 3, 0, '{4'b0000, 0, 0, 0, 4, 8, 28});
    step(28, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, '{4'b0000, 0, 0, 0, 8, 8, 32});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
